// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

    localparam int PC_WIDTH    = 16;
    localparam int INSTR_WIDTH = 16;
    localparam int ROM_DEPTH   = 100;
    localparam int RESET_PC    = 0;

    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP    = 16'd0;
    localparam logic [PC_WIDTH-1:0]    RESET_PC_V   = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0]    ROM_LAST_PC  = PC_WIDTH'(ROM_DEPTH - 1);
    localparam logic [PC_WIDTH-1:0]    ROM_DEPTH_PC = PC_WIDTH'(ROM_DEPTH);

    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    // True when the address names a real ROM word.
    function automatic logic addr_in_range(input logic [PC_WIDTH-1:0] addr);
        return (addr < ROM_DEPTH_PC);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus: ROM address/data, decode handshake, redirect and status.
interface fetch_if;
    import fetch_pkg::*;

    logic [PC_WIDTH-1:0]    pco_out;
    logic [INSTR_WIDTH-1:0] rom_instruction;
    logic                   ir_valid;
    logic                   ir_ready;
    logic [INSTR_WIDTH-1:0] ir_instr;
    logic [PC_WIDTH-1:0]    ir_pc;
    logic                   branch_en;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   halted;
    logic [15:0]            retired_count;

    modport master (
        output pco_out, ir_valid, ir_instr, ir_pc, halted, retired_count,
        input  rom_instruction, ir_ready, branch_en, branch_target
    );

    modport slave (
        input  pco_out, ir_valid, ir_instr, ir_pc, halted, retired_count,
        output rom_instruction, ir_ready, branch_en, branch_target
    );

endinterface

// File: rtl/fetch_addr_mux.sv
// Priority mux choosing the next ROM address: branch, stall, halt, sequential.
module fetch_addr_mux
    import fetch_pkg::*;
(
    input  logic                branch_en_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    input  logic                stall_i,
    input  logic                halt_i,
    input  logic [PC_WIDTH-1:0] cur_pc_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    output logic [PC_WIDTH-1:0] sel_o,
    output logic [PC_WIDTH-1:0] pco_out_o
);

    // Select the address by priority, then clamp so the ROM never sees an out-of-range address.
    always_comb begin
        sel_o = pc_i;
        if (branch_en_i) begin
            sel_o = branch_target_i;
        end else if (stall_i) begin
            sel_o = cur_pc_i;
        end else if (halt_i) begin
            sel_o = ROM_LAST_PC;
        end else begin
            sel_o = pc_i;
        end

        if (addr_in_range(sel_o)) begin
            pco_out_o = sel_o;
        end else begin
            pco_out_o = ROM_LAST_PC;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: tracks the in-flight ROM address, holds it under
// decode back-pressure, redirects on branches without a bubble and halts at end of memory.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] cur_pc_q, cur_pc_d;
    logic                cur_valid_q, cur_valid_d;
    fetch_state_t        state_q, state_d;
    logic [15:0]         retired_count_q, retired_count_d;

    logic                stall_s;
    logic                accept_s;
    logic [PC_WIDTH-1:0] sel_s;
    logic [PC_WIDTH-1:0] pco_s;

    // A branch always wins over back-pressure; only a presented word can stall.
    assign stall_s  = cur_valid_q && !bus.ir_ready && !bus.branch_en;
    assign accept_s = cur_valid_q && bus.ir_ready && !bus.branch_en;

    fetch_addr_mux u_addr_mux (
        .branch_en_i     (bus.branch_en),
        .branch_target_i (bus.branch_target),
        .stall_i         (stall_s),
        .halt_i          (state_q == FS_HALT),
        .cur_pc_i        (cur_pc_q),
        .pc_i            (pc_q),
        .sel_o           (sel_s),
        .pco_out_o       (pco_s)
    );

    // State register; reset clears the pipeline and the retire counter immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC_V;
            cur_pc_q        <= RESET_PC_V;
            cur_valid_q     <= 1'b0;
            state_q         <= FS_RUN;
            retired_count_q <= 16'd0;
        end else begin
            pc_q            <= pc_d;
            cur_pc_q        <= cur_pc_d;
            cur_valid_q     <= cur_valid_d;
            state_q         <= state_d;
            retired_count_q <= retired_count_d;
        end
    end

    // Next-state: hold on stall or idle halt, otherwise load the selected address or halt on overrun.
    always_comb begin
        pc_d            = pc_q;
        cur_pc_d        = cur_pc_q;
        cur_valid_d     = cur_valid_q;
        state_d         = state_q;
        retired_count_d = retired_count_q;

        if (stall_s) begin
            pc_d = pc_q;
        end else if ((state_q == FS_HALT) && !bus.branch_en) begin
            // Halted fetch only leaves on a redirect.
            state_d = FS_HALT;
        end else if (addr_in_range(sel_s)) begin
            cur_pc_d    = sel_s;
            cur_valid_d = 1'b1;
            pc_d        = sel_s + 16'd1;
            state_d     = FS_RUN;
        end else begin
            cur_valid_d = 1'b0;
            state_d     = FS_HALT;
        end

        if (accept_s && (retired_count_q != 16'hFFFF)) begin
            retired_count_d = retired_count_q + 16'd1;
        end else begin
            retired_count_d = retired_count_q;
        end
    end

    assign bus.pco_out       = pco_s;
    assign bus.ir_valid      = cur_valid_q;
    assign bus.ir_instr      = cur_valid_q ? bus.rom_instruction : INSTR_NOP;
    assign bus.ir_pc         = cur_pc_q;
    assign bus.halted        = (state_q == FS_HALT);
    assign bus.retired_count = retired_count_q;

endmodule
